// File: rtl/ad9911_pkg.sv
// ad9911_pkg: shared definitions for the AD9911 serial-port writer.
//   - register address constants
//   - ad9911_reg_bytes(): payload length in bytes for a register address
//     (0 = invalid)
//   - FSM state encoding
// Build option: AD9911_IO_UPDATE_EN adds the UPD state (writer-driven IO_UPDATE).
package ad9911_pkg;

    localparam logic [7:0] AD9911_CSR      = 8'h00;
    localparam logic [7:0] AD9911_FR1      = 8'h01;
    localparam logic [7:0] AD9911_FR2      = 8'h02;
    localparam logic [7:0] AD9911_CFR      = 8'h03;
    localparam logic [7:0] AD9911_CTW0     = 8'h04;
    localparam logic [7:0] AD9911_CPOW0    = 8'h05;
    localparam logic [7:0] AD9911_ACR      = 8'h06;
    localparam logic [7:0] AD9911_LSR      = 8'h07;
    localparam logic [7:0] AD9911_RDW      = 8'h08;
    localparam logic [7:0] AD9911_FDW      = 8'h09;
    localparam logic [7:0] AD9911_CTW1     = 8'h0A;
    localparam logic [7:0] AD9911_CTW_LAST = 8'h18;

    localparam int unsigned SHIFT_W   = 40;
    localparam int unsigned BIT_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REJECT = 2'd2
`ifdef AD9911_IO_UPDATE_EN
        ,
        ST_UPD    = 2'd3
`endif
    } ad9911_state_e;

    // Payload bytes for a register address; 0 marks an invalid address.
    function automatic logic [2:0] ad9911_reg_bytes(input logic [7:0] addr);
        logic [2:0] n;
        n = 3'd0;
        if (addr == AD9911_CSR)
            n = 3'd1;
        else if (addr == AD9911_FR2 || addr == AD9911_CPOW0 || addr == AD9911_LSR)
            n = 3'd2;
        else if (addr == AD9911_FR1 || addr == AD9911_CFR || addr == AD9911_ACR)
            n = 3'd3;
        else if (addr == AD9911_CTW0 || (addr >= AD9911_RDW && addr <= AD9911_CTW_LAST))
            n = 3'd4;
        return n;
    endfunction

endpackage

// File: rtl/ad9911_spi_writer_if.sv
// ad9911_spi_writer_if: register-write request handshake.
//   TR   write request (rising edge)      ADDR  register address
//   DATA right-aligned payload            BUSY  writer busy
// master = upstream requester, slave = SPI writer.
interface ad9911_spi_writer_if;
    logic        TR;
    logic [7:0]  ADDR;
    logic [31:0] DATA;
    logic        BUSY;

    modport master (output TR, output ADDR, output DATA, input BUSY);
    modport slave  (input TR, input ADDR, input DATA, output BUSY);
endinterface

// File: rtl/ad9911_sclk_tick.sv
// ad9911_sclk_tick: SCLK half-period divider.
//   CLOCK_10M, RESET_N  clock / async active-low reset
//   i_clear             synchronous restart of the half period
//   o_tick_c            high on the last cycle of each half period
module ad9911_sclk_tick #(
    parameter int unsigned SCLK_DIV = 1
) (
    input  logic CLOCK_10M,
    input  logic RESET_N,
    input  logic i_clear,
    output logic o_tick_c
);
    localparam logic [7:0] LAST = 8'(SCLK_DIV - 1);

    logic [7:0] r_cnt;

    assign o_tick_c = (r_cnt == LAST);

    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N)
            r_cnt <= 8'd0;
        else if (i_clear || o_tick_c)
            r_cnt <= 8'd0;
        else
            r_cnt <= r_cnt + 8'd1;
    end
endmodule

// File: rtl/ad9911_spi_writer.sv
// ad9911_spi_writer: AD9911 3-wire serial-port write master.
//   CLOCK_10M, RESET_N        10 MHz clock / async active-low reset
//   req (slave)               TR/ADDR/DATA request, BUSY answer
//   CS_N, SCLK, SDIO          serial port pins (SDIO MSB first)
//   IO_UPDATE                 register-transfer strobe
// Build option: AD9911_IO_UPDATE_EN pulses IO_UPDATE for IO_UPD_W cycles after
// each write; otherwise IO_UPDATE is tied low and the strobe is external.
module ad9911_spi_writer
    import ad9911_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 1,
    parameter int unsigned IO_UPD_W = 2
) (
    input  logic                 CLOCK_10M,
    input  logic                 RESET_N,
    ad9911_spi_writer_if.slave   req,
    output logic                 CS_N,
    output logic                 SCLK,
    output logic                 SDIO,
    output logic                 IO_UPDATE
);
    // Shared counter for REJECT (2 cycles) and the IO_UPDATE pulse.
    localparam int unsigned AUX_W = (IO_UPD_W > 3) ? 4 : 2;

    ad9911_state_e          r_state, w_state_nxt;
    logic                   r_tr_d;
    logic                   r_busy, w_busy_nxt;
    logic                   r_cs_n, w_cs_n_nxt;
    logic                   r_sclk, w_sclk_nxt;
    logic                   r_sdio, w_sdio_nxt;
    logic [SHIFT_W-1:0]     r_shift, w_shift_nxt, w_load;
    logic [BIT_CNT_W-1:0]   r_bit, w_bit_nxt;
    logic [BIT_CNT_W-1:0]   r_last_bit, w_last_bit_nxt;
    logic [AUX_W-1:0]       r_aux, w_aux_nxt;
    logic [2:0]             w_nbytes;
    logic                   w_accept;
    logic                   w_tick;

    ad9911_sclk_tick #(.SCLK_DIV(SCLK_DIV)) u_tick (
        .CLOCK_10M (CLOCK_10M),
        .RESET_N   (RESET_N),
        .i_clear   (w_accept),
        .o_tick_c  (w_tick)
    );

    assign req.BUSY = r_busy;
    assign CS_N     = r_cs_n;
    assign SCLK     = r_sclk;
    assign SDIO     = r_sdio;

`ifdef AD9911_IO_UPDATE_EN
    logic r_io_upd, w_io_upd_nxt;
    assign IO_UPDATE = r_io_upd;
`else
    assign IO_UPDATE = 1'b0;
`endif

    // Instruction byte over the low N payload bytes, left-justified, zero-filled.
    always_comb begin
        w_nbytes = ad9911_reg_bytes(req.ADDR);
        case (w_nbytes)
            3'd1:    w_load = {3'b000, req.ADDR[4:0], req.DATA[7:0],  24'd0};
            3'd2:    w_load = {3'b000, req.ADDR[4:0], req.DATA[15:0], 16'd0};
            3'd3:    w_load = {3'b000, req.ADDR[4:0], req.DATA[23:0], 8'd0};
            default: w_load = {3'b000, req.ADDR[4:0], req.DATA};
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_busy_nxt     = r_busy;
        w_cs_n_nxt     = r_cs_n;
        w_sclk_nxt     = r_sclk;
        w_sdio_nxt     = r_sdio;
        w_shift_nxt    = r_shift;
        w_bit_nxt      = r_bit;
        w_last_bit_nxt = r_last_bit;
        w_aux_nxt      = r_aux;
        w_accept       = 1'b0;
`ifdef AD9911_IO_UPDATE_EN
        w_io_upd_nxt   = r_io_upd;
`endif
        case (r_state)
            ST_IDLE: begin
                if (req.TR && !r_tr_d) begin
                    w_busy_nxt = 1'b1;
                    if (w_nbytes != 3'd0) begin
                        w_accept       = 1'b1;
                        w_state_nxt    = ST_SHIFT;
                        w_cs_n_nxt     = 1'b0;
                        w_sclk_nxt     = 1'b0;
                        w_shift_nxt    = w_load;
                        w_sdio_nxt     = w_load[SHIFT_W-1];
                        w_bit_nxt      = '0;
                        // 8N+7 = index of the last bit of an 8+8N bit frame
                        w_last_bit_nxt = {w_nbytes, 3'b111};
                    end else begin
                        w_state_nxt = ST_REJECT;
                        w_aux_nxt   = '0;
                    end
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else if (r_bit == r_last_bit) begin
                        w_cs_n_nxt = 1'b1;
                        w_sclk_nxt = 1'b0;
                        w_sdio_nxt = 1'b0;
`ifdef AD9911_IO_UPDATE_EN
                        w_state_nxt  = ST_UPD;
                        w_io_upd_nxt = 1'b1;
                        w_aux_nxt    = '0;
`else
                        w_state_nxt  = ST_IDLE;
                        w_busy_nxt   = 1'b0;
`endif
                    end else begin
                        // SDIO moves to the next bit as SCLK falls
                        w_sclk_nxt  = 1'b0;
                        w_bit_nxt   = r_bit + BIT_CNT_W'(1);
                        w_shift_nxt = {r_shift[SHIFT_W-2:0], 1'b0};
                        w_sdio_nxt  = r_shift[SHIFT_W-2];
                    end
                end
            end
            ST_REJECT: begin
                if (r_aux == AUX_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_aux_nxt = r_aux + AUX_W'(1);
                end
            end
`ifdef AD9911_IO_UPDATE_EN
            ST_UPD: begin
                if (r_aux == AUX_W'(IO_UPD_W - 1)) begin
                    w_state_nxt  = ST_IDLE;
                    w_busy_nxt   = 1'b0;
                    w_io_upd_nxt = 1'b0;
                end else begin
                    w_aux_nxt = r_aux + AUX_W'(1);
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_tr_d     <= 1'b0;
            r_busy     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_sclk     <= 1'b0;
            r_sdio     <= 1'b0;
            r_shift    <= '0;
            r_bit      <= '0;
            r_last_bit <= '0;
            r_aux      <= '0;
`ifdef AD9911_IO_UPDATE_EN
            r_io_upd   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_tr_d     <= req.TR;
            r_busy     <= w_busy_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_sclk     <= w_sclk_nxt;
            r_sdio     <= w_sdio_nxt;
            r_shift    <= w_shift_nxt;
            r_bit      <= w_bit_nxt;
            r_last_bit <= w_last_bit_nxt;
            r_aux      <= w_aux_nxt;
`ifdef AD9911_IO_UPDATE_EN
            r_io_upd   <= w_io_upd_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_ad9911_spi_writer.sv
// tb_ad9911_spi_writer: bench for ad9911_spi_writer.
// Two instances (SCLK_DIV=1/IO_UPD_W=2 and SCLK_DIV=3/IO_UPD_W=3) share clock
// and reset. Every cycle of every write is compared against a cycle-indexed
// reference built from the register length table and the frame timing rules.
module tb_ad9911_spi_writer;

`ifdef AD9911_IO_UPDATE_EN
    localparam bit UPD_EN = 1'b1;
`else
    localparam bit UPD_EN = 1'b0;
`endif
    localparam int D_A = 1, W_A = 2, D_B = 3, W_B = 3;
    localparam logic [4:0] IDLE_VEC = 5'b01000; // {busy,cs_n,sclk,sdio,io_update}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ad9911_spi_writer_if req_a ();
    ad9911_spi_writer_if req_b ();
    logic cs_n_a, sclk_a, sdio_a, iou_a;
    logic cs_n_b, sclk_b, sdio_b, iou_b;

    ad9911_spi_writer #(.SCLK_DIV(D_A), .IO_UPD_W(W_A)) dut_a (
        .CLOCK_10M (clk), .RESET_N (rst_n), .req (req_a),
        .CS_N (cs_n_a), .SCLK (sclk_a), .SDIO (sdio_a), .IO_UPDATE (iou_a)
    );
    ad9911_spi_writer #(.SCLK_DIV(D_B), .IO_UPD_W(W_B)) dut_b (
        .CLOCK_10M (clk), .RESET_N (rst_n), .req (req_b),
        .CS_N (cs_n_b), .SCLK (sclk_b), .SDIO (sdio_b), .IO_UPDATE (iou_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Register length table.
    function automatic int ref_nbytes(input logic [7:0] a);
        if (a == 8'h00) return 1;
        if (a == 8'h02 || a == 8'h05 || a == 8'h07) return 2;
        if (a == 8'h01 || a == 8'h03 || a == 8'h06) return 3;
        if (a == 8'h04 || (a >= 8'h08 && a <= 8'h18)) return 4;
        return 0;
    endfunction

    // Frame as an integer: instruction byte above the low N data bytes.
    function automatic logic [63:0] ref_word(input logic [7:0] a, input logic [31:0] d);
        int n;
        n = ref_nbytes(a);
        return (64'(a & 8'h1F) << (8 * n)) | (64'(d) & ((64'd1 << (8 * n)) - 64'd1));
    endfunction

    // Expected pins in cycle c after the accepting edge.
    function automatic logic [4:0] ref_vec(input int c, input logic [7:0] a,
                                           input logic [31:0] d, input int dv, input int w);
        int n, b, last, k, ph;
        logic [63:0] word;
        n = ref_nbytes(a);
        if (n == 0)
            return {(c == 1 || c == 2) ? 1'b1 : 1'b0, 4'b1000};
        b = 8 + 8 * n;
        last = 2 * dv * b;
        word = ref_word(a, d);
        if (c >= 1 && c <= last) begin
            k  = (c - 1) / (2 * dv);
            ph = (c - 1) % (2 * dv);
            return {1'b1, 1'b0, (ph >= dv) ? 1'b1 : 1'b0, word[b - 1 - k], 1'b0};
        end
        if (UPD_EN && c <= last + w)
            return 5'b11001;
        return IDLE_VEC;
    endfunction

    function automatic logic [4:0] dut_vec(input int sel);
        if (sel != 0) return {req_b.BUSY, cs_n_b, sclk_b, sdio_b, iou_b};
        return {req_a.BUSY, cs_n_a, sclk_a, sdio_a, iou_a};
    endfunction

    task automatic set_req(input int sel, input logic tr, input logic [7:0] a, input logic [31:0] d);
        if (sel != 0) begin req_b.TR = tr; req_b.ADDR = a; req_b.DATA = d; end
        else          begin req_a.TR = tr; req_a.ADDR = a; req_a.DATA = d; end
    endtask

    // One request: TR high for `hold` cycles (plus an optional second pulse
    // g0..g1), every cycle compared; returns the bits captured on SCLK rises.
    // abort_c > 0 drops RESET_N in that cycle instead of finishing the frame.
    task automatic run_write(input int sel, input logic [7:0] a, input logic [31:0] d,
                             input int hold, input int g0, input int g1, input int abort_c,
                             input string name, output logic [63:0] cap, output int ncap);
        int dv, w, n, endc, len;
        logic prev, tr;
        logic [4:0] v, e;
        dv = (sel != 0) ? D_B : D_A;
        w  = (sel != 0) ? W_B : W_A;
        n  = ref_nbytes(a);
        endc = (n == 0) ? 2 : 2 * dv * (8 + 8 * n) + (UPD_EN ? w : 0);
        len = ((hold > endc) ? hold : endc) + 4;
        if (g1 + 4 > len) len = g1 + 4;
        cap = '0; ncap = 0; prev = 1'b0;
        @(negedge clk);
        set_req(sel, 1'b1, a, d);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            v = dut_vec(sel);
            e = ref_vec(c, a, d, dv, w);
            n_vec++;
            if (v !== e) begin
                n_err++;
                if (n_err <= 20)
                    $display("FAIL %s cycle %0d: {busy,cs_n,sclk,sdio,io_update} got %b want %b",
                             name, c, v, e);
            end
            if (!prev && v[2]) begin cap = {cap[62:0], v[1]}; ncap++; end
            prev = v[2];
            if (c == abort_c) begin
                rst_n = 1'b0;
                set_req(sel, 1'b0, a, d);
                #1;
                n_vec++;
                if (dut_vec(sel) !== IDLE_VEC) begin
                    n_err++;
                    $display("FAIL %s reset-in-frame: pins got %b want %b", name, dut_vec(sel), IDLE_VEC);
                end
                return;
            end
            tr = (c < hold) || (c >= g0 && c < g1);
            set_req(sel, tr, a, d);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_vec++;
            if (dut_vec(s) !== IDLE_VEC) begin
                n_err++;
                $display("FAIL reset_held dut%0d: got %b want %b", s, dut_vec(s), IDLE_VEC);
            end
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_vec++;
            if (dut_vec(s) !== IDLE_VEC) begin
                n_err++;
                $display("FAIL reset_release dut%0d: got %b want %b", s, dut_vec(s), IDLE_VEC);
            end
        end
    endtask

    task automatic test_ctw0();
        logic [63:0] cap; int ncap;
        run_write(0, 8'h04, 32'h16147AE1, 3, 0, 0, 0, "ctw0", cap, ncap);
        n_vec++;
        if (ncap !== 40 || cap !== 64'h04_16147AE1) begin
            n_err++;
            $display("FAIL ctw0_stream: got %0d bits %h want 40 bits 0416147ae1", ncap, cap);
        end
    endtask

    task automatic test_csr();
        logic [63:0] cap; int ncap;
        run_write(1, 8'h00, 32'hA5C3_9920, 4, 0, 0, 0, "csr_d3", cap, ncap);
        n_vec++;
        if (ncap !== 16 || cap !== 64'h0020) begin
            n_err++;
            $display("FAIL csr_stream: got %0d bits %h want 16 bits 0020", ncap, cap);
        end
    endtask

    task automatic test_invalid();
        logic [63:0] cap; int ncap;
        logic [31:0] d;
        run_write(0, 8'h1F, 32'hDEADBEEF, 2, 0, 0, 0, "invalid_1f", cap, ncap);
        n_vec++;
        if (ncap !== 0) begin
            n_err++;
            $display("FAIL invalid_sclk: got %0d SCLK rises want 0", ncap);
        end
        d = $urandom;
        run_write(0, 8'h07, d, 2, 0, 0, 0, "after_invalid", cap, ncap);
        n_vec++;
        if (ncap !== 24 || cap !== {40'd0, 8'h07, d[15:0]}) begin
            n_err++;
            $display("FAIL after_invalid_stream: got %0d bits %h want 24 bits %h", ncap, cap, {8'h07, d[15:0]});
        end
    endtask

    task automatic test_tr_held();
        logic [63:0] cap; int ncap;
        logic [31:0] d;
        d = $urandom;
        run_write(0, 8'h01, d, 200, 0, 0, 0, "fr1_tr_held", cap, ncap);
        n_vec++;
        if (ncap !== 32 || cap !== {32'd0, 8'h01, d[23:0]}) begin
            n_err++;
            $display("FAIL tr_held_stream: got %0d bits %h want 32 bits %h", ncap, cap, {8'h01, d[23:0]});
        end
        run_write(1, 8'h05, d, 2, 20, 30, 0, "pulse_in_busy", cap, ncap);
        n_vec++;
        if (ncap !== 24) begin
            n_err++;
            $display("FAIL pulse_in_busy_bits: got %0d want 24", ncap);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] cap; int ncap;
        run_write(0, 8'h04, $urandom, 3, 0, 0, 21, "ctw0_abort", cap, ncap);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_write(0, 8'h04, 32'h16147AE1, 3, 0, 0, 0, "ctw0_after_reset", cap, ncap);
        n_vec++;
        if (ncap !== 40 || cap !== 64'h04_16147AE1) begin
            n_err++;
            $display("FAIL after_reset_stream: got %0d bits %h want 40 bits 0416147ae1", ncap, cap);
        end
    endtask

    task automatic test_random();
        logic [63:0] cap; int ncap, sel, n, hold;
        logic [7:0] a; logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            sel  = $urandom_range(0, 1);
            a    = 8'($urandom_range(0, 31));
            d    = $urandom;
            hold = $urandom_range(1, 6);
            n    = ref_nbytes(a);
            run_write(sel, a, d, hold, 0, 0, 0, "random", cap, ncap);
            n_vec++;
            if (ncap !== ((n == 0) ? 0 : 8 + 8 * n) || (n != 0 && cap !== ref_word(a, d))) begin
                n_err++;
                $display("FAIL random_stream addr %h data %h: got %0d bits %h want %h",
                         a, d, ncap, cap, ref_word(a, d));
            end
        end
    endtask

    initial begin
        set_req(0, 1'b0, 8'h00, 32'h0);
        set_req(1, 1'b0, 8'h00, 32'h0);
        test_reset();
        test_ctw0();
        test_csr();
        test_invalid();
        test_tr_held();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ad9911_spi_writer.md
# ad9911_spi_writer

Serial-port master for one AD9911 DDS. Sits directly downstream of the frequency-updater stage: it accepts a register write as a TR/ADDR/DATA request, answers on BUSY, and shifts the instruction byte plus the register payload onto the chip's 3-wire SPI pins. It then optionally pulses IO_UPDATE. One instance serves each DDS (LO and RF).

## Interface
- SCLK_DIV, 1: SCLK half-period in CLOCK_10M cycles, range 1..255 (1 gives 5 MHz SCLK).
- IO_UPD_W, 2: IO_UPDATE pulse width in cycles, range 1..15.
- CLOCK_10M  in  1  system clock, 10 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- TR  in  1  write request; acted on at its rising edge only.
- ADDR  in  8  AD9911 register address; bits [4:0] are used.
- DATA  in  32  payload, right-aligned; only the low 8·N bits are sent.
- BUSY  out  1  high from the cycle after acceptance until the transfer completes.
- CS_N  out  1  chip select, active low.
- SCLK  out  1  serial clock; idles low.
- SDIO  out  1  serial data, MSB first; changes only while SCLK is low.
- IO_UPDATE  out  1  register-transfer strobe (see Configuration).

## Operation
- Payload length N in bytes, decoded from ADDR at acceptance:
  - 0x00 → 1
  - 0x02, 0x05, 0x07 → 2
  - 0x01, 0x03, 0x06 → 3
  - 0x04, 0x08–0x18 → 4
  - ADDR > 0x18 is invalid.
- Instruction byte: {1'b0 (write), 2'b00, ADDR[4:0]}.
- A 40-bit shift register is loaded at acceptance: instruction byte in [39:32], then DATA[8N-1:0] left-justified below it, zero-filled. The transfer length is 8+8N bits.
- TR edge detection uses a registered copy TR_d. A request is accepted when the FSM is in IDLE and TR & ~TR_d. A TR held high across a transfer does not retrigger. Edges that occur while BUSY is high are ignored.
- FSM states and transitions:
  - IDLE → SHIFT on a valid accept; IDLE → REJECT on an invalid ADDR.
  - SHIFT: bit counter 0..8+8N-1, each bit split into a SCLK-low half and a SCLK-high half. After the last bit → UPD if the macro is defined, else IDLE.
  - UPD: IO_UPDATE high for IO_UPD_W cycles, then IDLE.
  - REJECT: BUSY high for 2 cycles. CS_N, SCLK and IO_UPDATE stay idle. Then IDLE.
- A half-period counter (0..SCLK_DIV-1) produces the tick that advances SCLK phase.

## Timing
- Reset value of every output, and the state on assertion of RESET_N at any time (including mid-transfer):
  - BUSY=0, CS_N=1, SCLK=0, SDIO=0, IO_UPDATE=0, FSM=IDLE, TR_d=0.
- T0 is the accepting clock edge. Let D=SCLK_DIV and B=8+8N.
- From T0+1: BUSY=1, CS_N=0, SDIO = bit 39.
- Bit k occupies cycles T0+1+2Dk .. T0+2D(k+1):
  - SCLK is low for the first D cycles and high for the last D cycles.
  - SDIO updates to the next bit on the cycle SCLK returns low.
- At T0+1+2DB: CS_N=1, SCLK=0, SDIO=0.
  - With the macro: IO_UPDATE is high for cycles T0+1+2DB .. T0+2DB+IO_UPD_W, and BUSY falls at T0+1+2DB+IO_UPD_W.
  - Without the macro: BUSY falls at T0+1+2DB.
- REJECT: BUSY is high in cycles T0+1 and T0+2, and low from T0+3.
- The upstream handshake (raise TR, wait for BUSY=1, drop TR, wait for BUSY=0) always completes, because BUSY stays high for at least 2 cycles.

## Configuration
- AD9911_IO_UPDATE_EN defined:
  - Every successful write ends with the IO_UPDATE pulse before BUSY falls.
  - Register contents become active immediately.
- AD9911_IO_UPDATE_EN undefined:
  - IO_UPDATE is tied to 0 and the UPD state does not exist.
  - The update strobe is issued externally.

## Structure
- Shared package ad9911_pkg holds:
  - register address constants (CSR, FR1, FR2, CFR, CTW0, CPOW0, ACR, LSR, RDW, FDW, CTW1, CTW_LAST=0x18);
  - the function ad9911_reg_bytes(addr) returning N, with 0 meaning invalid;
  - the FSM state enum.
- One sub-module: ad9911_sclk_tick, the SCLK_DIV half-period counter with a tick output and a synchronous clear on acceptance.

## Test plan
- Reset mid-transfer: assert RESET_N=0 at bit 10 of a CTW0 write → all outputs return to idle values in the same cycle; a new TR edge after release starts a fresh transfer.
- CTW0 write, D=1, W=2, macro defined: ADDR=0x04, DATA=0x16147AE1 → SDIO stream 0x04_16147AE1 (40 bits, MSB first) sampled on SCLK rises; CS_N low for 80 cycles; IO_UPDATE high for 2 cycles; BUSY high T0+1..T0+82.
- CSR write, D=3: ADDR=0x00, DATA=0x00000020 → 16 bits 0x0020; each SCLK phase lasts 3 cycles; upper DATA bits are not sent.
- Invalid ADDR=0x1F → BUSY high exactly 2 cycles; no CS_N or SCLK activity; a following valid write proceeds normally.
- TR held high for 200 cycles over a FR1 write (ADDR=0x01) → exactly one 32-bit transfer; a TR pulse arriving during BUSY is ignored.
- Macro undefined: repeat the CTW0 case → IO_UPDATE stays 0 and BUSY falls at T0+81.
